handshake_fifo: RTL and testbench
=================================

HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits, range 1..1024.
REQ-002 Parameter DEPTH, default 16: total capacity in entries, output register included; any integer from 2 to 4096, power of two not required.
REQ-003 Parameter AF_THRESH, default DEPTH-4: almost_full asserts when level >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 4: almost_empty asserts when level <= AE_THRESH.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_data  input  DATA_WIDTH  write payload.
REQ-009 in_ready  output  1  FIFO accepts a word this cycle.
REQ-010 out_valid  output  1  out_data holds the head entry.
REQ-011 out_data  output  DATA_WIDTH  head payload, driven from a register.
REQ-012 out_ready  input  1  downstream consumes the head this cycle.
REQ-013 level  output  $clog2(DEPTH+1)  entries stored, output register included.
REQ-014 full, empty, almost_full, almost_empty  output  1 each  status flags derived from level.

Function
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-016 in_ready is the registered value of (level < DEPTH) and has no combinational path from out_ready.
REQ-017 Output is first-word-fall-through: a push into an empty FIFO drives out_valid=1 with that word on the next cycle, so latency is 1.
REQ-018 out_data and out_valid are held stable while out_valid && !out_ready.
REQ-019 On a pop with RAM entries pending, the next entry loads into the output register in the same cycle, giving back-to-back throughput of 1 word per cycle.
REQ-020 When level == 1, the word is in the output register, and push and pop occur together, the pushed word bypasses the RAM into the output register; out_valid stays 1.
REQ-021 Push and pop in the same cycle leave level unchanged; push only adds 1; pop only subtracts 1.
REQ-022 RAM pointers wrap from DEPTH-2 to 0 for any DEPTH; the RAM holds DEPTH-1 entries.
REQ-023 At full (level == DEPTH) with a pop, in_ready rises one cycle later; a push in the pop cycle is impossible because in_ready=0.
REQ-024 Data order is strictly FIFO; no word is dropped or duplicated under any push/pop pattern.
REQ-025 full = (level == DEPTH); empty = (level == 0); almost_full and almost_empty are combinational compares on level.

Reset
REQ-026 While rst=1, all pointers and level are 0; out_valid=0; in_ready=0; full=0; empty=1; almost_empty=1; almost_full=0 unless AF_THRESH == 0.
REQ-027 in_ready rises on the first cycle after rst deasserts.
REQ-028 Reset asserted mid-transfer discards all contents and ignores the push/pop of that cycle.
REQ-029 RAM contents are not reset.

Configuration
REQ-030 Macro HANDSHAKE_FIFO_FLUSH_EN: when defined, an input port flush (1 bit) exists; flush=1 clears level, pointers and out_valid in the next cycle, takes priority over a push or pop in the same cycle, and leaves in_ready registered normally.
REQ-031 When HANDSHAKE_FIFO_FLUSH_EN is undefined, the flush port does not exist and behaviour is REQ-015..REQ-029 only.

Structure
REQ-032 Package fifo_pkg holds the level-width function (clog2 of DEPTH+1) and the pointer-increment-with-wrap function; the module imports both.
REQ-033 Storage is sub-module fifo_ram: 1 write port, 1 synchronous read port, parametrised by DATA_WIDTH and number of entries; control stays in handshake_fifo.

Verification
REQ-034 DEPTH=5: push 5 words 0x11..0x15 with out_ready=0 -> level=5, full=1, in_ready=0 one cycle after the 5th push, out_data=0x11.
REQ-035 From full, out_ready=1 and in_valid=1 for 10 cycles -> outputs 0x11..0x15 then the new words in order, with no gap once in_ready returns.
REQ-036 Empty FIFO, single push 0xAB -> out_valid=1 and out_data=0xAB on the next cycle; level=1.
REQ-037 level=1, push 0xCD and pop together -> out_data=0xCD next cycle, level=1, out_valid stays 1.
REQ-038 Random valid/ready at 50% each for 10000 cycles with DEPTH=7 -> scoreboard matches, and level never exceeds 7 or underflows.
REQ-039 With HANDSHAKE_FIFO_FLUSH_EN: level=3, flush=1 with a push -> next cycle level=0, out_valid=0, empty=1, and the pushed word is discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing and pointer helpers for the handshake FIFO and its storage.
package fifo_pkg;

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // Wraps at the last valid entry, so non-power-of-two storage works.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned entries);
        return (ptr >= entries - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage, one write and one registered read; read data valid the cycle after the address.
// Write-first on an address collision; no backpressure, control lives in the caller.
module fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 15,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o
);

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
    logic [DATA_WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        // Forward the word being written so a freshly written head is visible next cycle.
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_dat_q <= wr_dat_i;
        end else begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FWFT FIFO with a registered head; latency 1, 1 word/cycle; in_ready registered from level.
// Optional synchronous flush port under HANDSHAKE_FIFO_FLUSH_EN.
module handshake_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef HANDSHAKE_FIFO_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic [lvl_width(DEPTH)-1:0] level,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int RAM_N = DEPTH - 1;
    localparam int PW    = ptr_width(RAM_N);
    localparam int LW    = lvl_width(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] ram_rd_dat;
    logic                  flush_w;
    logic                  push, pop, ram_empty, load_in, load_ram, ram_wr;

`ifdef HANDSHAKE_FIFO_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_comb begin
        push      = in_valid && in_ready_q;
        pop       = out_valid_q && out_ready;
        // The head register always holds the oldest word, so RAM is empty at level <= 1.
        ram_empty = (level_q <= LW'(1));
        load_in   = push && (!out_valid_q || (pop && ram_empty));
        load_ram  = pop && !ram_empty;
        ram_wr    = push && !load_in;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (ram_wr) begin
            wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), RAM_N));
        end

        if (load_ram) begin
            rd_ptr_d   = PW'(ptr_inc(32'(rd_ptr_q), RAM_N));
            out_data_d = ram_rd_dat;
        end else if (load_in) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end

        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end

        if (flush_w) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= (level_d < LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    // Read address runs one step ahead so the next head is ready at the pop edge.
    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ENTRIES    (RAM_N),
        .AW         (PW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr && !flush_w),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (in_data),
        .rd_addr_i (rd_ptr_d),
        .rd_dat_o  (ram_rd_dat)
    );

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign level        = level_q;
    assign full         = (level_q == LW'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (int'(level_q) >= AF_THRESH);
    assign almost_empty = (int'(level_q) <= AE_THRESH);

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: directed cases on a DEPTH=5 instance, random traffic on a DEPTH=7 instance.
module tb_handshake_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_level;
    logic        a_full, a_empty, a_af, a_ae;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_level;
    logic        b_full, b_empty, b_af, b_ae;
`ifdef HANDSHAKE_FIFO_FLUSH_EN
    logic        a_flush;
`endif

    handshake_fifo #(.DATA_WIDTH(32), .DEPTH(5)) u_dut_a (
        .clk          (clk),
        .rst          (rst),
`ifdef HANDSHAKE_FIFO_FLUSH_EN
        .flush        (a_flush),
`endif
        .in_valid     (a_in_valid),
        .in_data      (a_in_data),
        .in_ready     (a_in_ready),
        .out_valid    (a_out_valid),
        .out_data     (a_out_data),
        .out_ready    (a_out_ready),
        .level        (a_level),
        .full         (a_full),
        .empty        (a_empty),
        .almost_full  (a_af),
        .almost_empty (a_ae)
    );

    handshake_fifo #(.DATA_WIDTH(32), .DEPTH(7)) u_dut_b (
        .clk          (clk),
        .rst          (rst),
`ifdef HANDSHAKE_FIFO_FLUSH_EN
        .flush        (1'b0),
`endif
        .in_valid     (b_in_valid),
        .in_data      (b_in_data),
        .in_ready     (b_in_ready),
        .out_valid    (b_out_valid),
        .out_data     (b_out_data),
        .out_ready    (b_out_ready),
        .level        (b_level),
        .full         (b_full),
        .empty        (b_empty),
        .almost_full  (b_af),
        .almost_empty (b_ae)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int a_pops = 0;
    int since_rst = 0;

    always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

    // Scoreboard A: compares the head on each pop, records each accepted push.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
`ifdef HANDSHAKE_FIFO_FLUSH_EN
        end else if (a_flush) begin
            qa.delete();
`endif
        end else begin
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) check("a_spurious_pop", 32'(a_out_valid), 32'd0);
                else begin
                    check("a_sb_data", a_out_data, qa.pop_front());
                    a_pops++;
                end
            end
            if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
        end
    end

    // Scoreboard B also checks level and flags against the model occupancy every cycle.
    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
        end else begin
            if (since_rst >= 1) begin
                check("b_level", 32'(b_level), 32'(qb.size()));
                check("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 7));
                check("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
                check("b_full", 32'(b_full), 32'(qb.size() == 7));
                check("b_empty", 32'(b_empty), 32'(qb.size() == 0));
                check("b_almost_full", 32'(b_af), 32'(qb.size() >= 3));
                check("b_almost_empty", 32'(b_ae), 32'(qb.size() <= 4));
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) check("b_spurious_pop", 32'(b_out_valid), 32'd0);
                else check("b_sb_data", b_out_data, qb.pop_front());
            end
            if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  pops_base;
        int  idx;
        logic acc;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
`ifdef HANDSHAKE_FIFO_FLUSH_EN
        a_flush = 1'b0;
`endif
        repeat (3) tick();
        check("rst_level", 32'(a_level), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_full", 32'(a_full), 32'd0);
        check("rst_empty", 32'(a_empty), 32'd1);
        check("rst_almost_empty", 32'(a_ae), 32'd1);
        check("rst_almost_full", 32'(a_af), 32'd0);
        rst = 1'b0;
        tick();
        check("rdy_after_rst", 32'(a_in_ready), 32'd1);

        // Fill DEPTH=5 with the head held.
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h11 + 32'(i);
            tick();
        end
        a_in_valid = 1'b0;
        check("fill_level", 32'(a_level), 32'd5);
        check("fill_full", 32'(a_full), 32'd1);
        check("fill_in_ready", 32'(a_in_ready), 32'd0);
        check("fill_out_valid", 32'(a_out_valid), 32'd1);
        check("fill_out_data", a_out_data, 32'h11);
        check("fill_almost_full", 32'(a_af), 32'd1);
        check("fill_almost_empty", 32'(a_ae), 32'd0);

        a_in_valid = 1'b1;
        a_in_data  = 32'hEE;
        tick();
        check("full_hold_level", 32'(a_level), 32'd5);
        check("full_hold_data", a_out_data, 32'h11);

        // Stream from full: one pop per cycle, pushes resume once in_ready returns.
        pops_base = a_pops;
        idx = 0;
        a_in_data = 32'h21;
        a_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            acc = a_in_valid && a_in_ready;
            tick();
            check("stream_out_valid", 32'(a_out_valid), 32'd1);
            if (acc) begin
                idx++;
                a_in_data = 32'h21 + 32'(idx);
            end
        end
        a_in_valid = 1'b0;
        check("stream_pops", 32'(a_pops - pops_base), 32'd10);
        check("stream_level", 32'(a_level), 32'd4);
        for (int k = 0; k < 20 && !a_empty; k++) tick();
        a_out_ready = 1'b0;
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_sb_left", 32'(qa.size()), 32'd0);

        // Single push into empty, then push+pop at level 1.
        a_in_valid = 1'b1; a_in_data = 32'hAB;
        tick();
        a_in_valid = 1'b0;
        check("fwft_out_valid", 32'(a_out_valid), 32'd1);
        check("fwft_out_data", a_out_data, 32'hAB);
        check("fwft_level", 32'(a_level), 32'd1);
        a_in_valid = 1'b1; a_in_data = 32'hCD; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        check("bypass_out_data", a_out_data, 32'hCD);
        check("bypass_level", 32'(a_level), 32'd1);
        check("bypass_out_valid", 32'(a_out_valid), 32'd1);
        a_in_valid = 1'b1; a_in_data = 32'hE1;
        tick();
        a_in_valid = 1'b0;
        check("ram_push_level", 32'(a_level), 32'd2);
        a_out_ready = 1'b1;
        tick();
        check("ram_head_data", a_out_data, 32'hE1);
        tick();
        a_out_ready = 1'b0;
        check("ram_head_empty", 32'(a_empty), 32'd1);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h31 + 32'(i);
            tick();
        end
        a_in_data = 32'h77; a_out_ready = 1'b1; rst = 1'b1;
        tick();
        check("midrst_level", 32'(a_level), 32'd0);
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_in_ready", 32'(a_in_ready), 32'd0);
        rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        tick();
        check("midrst_rdy_back", 32'(a_in_ready), 32'd1);
        check("midrst_empty", 32'(a_empty), 32'd1);

`ifdef HANDSHAKE_FIFO_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h41 + 32'(i);
            tick();
        end
        check("pre_flush_level", 32'(a_level), 32'd3);
        a_flush = 1'b1; a_in_data = 32'h99;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("flush_level", 32'(a_level), 32'd0);
        check("flush_out_valid", 32'(a_out_valid), 32'd0);
        check("flush_empty", 32'(a_empty), 32'd1);
        check("flush_in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1; a_in_data = 32'h5A;
        tick();
        a_in_valid = 1'b0;
        check("post_flush_data", a_out_data, 32'h5A);
        check("post_flush_level", 32'(a_level), 32'd1);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
`endif

        // Random 50% valid/ready traffic on DEPTH=7.
        for (int c = 0; c < 10000; c++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_data   = $urandom;
            b_out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 0; k < 20 && !b_empty; k++) tick();
        b_out_ready = 1'b0;
        tick();
        check("rand_drain_empty", 32'(b_empty), 32'd1);
        check("rand_sb_left", 32'(qb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
